// File: rtl/queue_sensor_encoder.sv
// Two-lane queue estimator for smart_traffic_light. Each lane debounces its loop detector,
// counts arrivals, retires one car per DEPART_CYC green cycles and emits a thermometer code.
module queue_sensor_encoder #(
  parameter int DEB_CYC    = 4,
  parameter int DEPART_CYC = 8,
  parameter int MAXQ       = 15,
  parameter int QW         = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          det_main,
  input  logic          det_left,
  input  logic [2:0]    RYG,
  input  logic [3:0]    LRYG,
  output logic [2:0]    L,
  output logic [2:0]    H,
  output logic [QW-1:0] q_main,
  output logic [QW-1:0] q_left
);

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int TW = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;

  logic [1:0]          w_raw;
  logic [1:0]          w_green;
  logic [1:0][2:0]     w_code;
  logic [1:0][QW-1:0]  w_cnt;
  logic                w_unused_lights;

  assign w_raw   = {det_left, det_main};
  assign w_green = {LRYG[0] | LRYG[1], RYG[0]};

  // Red/yellow aspects carry no queue information.
  assign w_unused_lights = ^{RYG[2:1], LRYG[3:2]};

  function automatic logic [2:0] therm(input logic [QW-1:0] c);
    logic [2:0] t;
    if (c == '0)
      t = 3'b000;
    else if (c == QW'(1))
      t = 3'b100;
    else if (c == QW'(2))
      t = 3'b110;
    else
      t = 3'b111;
    return t;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [DW-1:0] r_stab;
      logic          r_deb;
      logic          r_deb_d;
      logic [TW-1:0] r_tmr;
      logic [QW-1:0] r_cnt;
      logic [2:0]    r_code;
      logic          w_arr;
      logic          w_run;
      logic          w_dep;

      assign w_arr = r_deb & ~r_deb_d;
      assign w_run = w_green[gi] && (r_cnt != '0);
      assign w_dep = w_run && (r_tmr == TW'(DEPART_CYC - 1));

      // Debounced level only follows raw after DEB_CYC consecutive disagreeing samples.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_stab  <= '0;
          r_deb   <= 1'b0;
          r_deb_d <= 1'b0;
        end else begin
          r_deb_d <= r_deb;
          if (w_raw[gi] == r_deb) begin
            r_stab <= '0;
          end else if (r_stab == DW'(DEB_CYC - 1)) begin
            r_deb  <= w_raw[gi];
            r_stab <= '0;
          end else begin
            r_stab <= r_stab + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          r_tmr <= '0;
        else if (!w_run || w_dep)
          r_tmr <= '0;
        else
          r_tmr <= r_tmr + 1'b1;
      end

      // A simultaneous arrival and departure cancel out.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cnt <= '0;
        end else if (w_arr && !w_dep) begin
          if (r_cnt != QW'(MAXQ))
            r_cnt <= r_cnt + 1'b1;
        end else if (w_dep && !w_arr) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          r_code <= 3'b000;
        else
          r_code <= therm(r_cnt);
      end

      assign w_code[gi] = r_code;
      assign w_cnt[gi]  = r_cnt;
    end
  endgenerate

  assign L      = w_code[0];
  assign H      = w_code[1];
  assign q_main = w_cnt[0];
  assign q_left = w_cnt[1];

endmodule
